// File: rtl/pipeline_ctrl.sv
// Hazard/flush controller: stall level, jump flush vector, fetch redirect.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
`ifndef StallLevelLen
`define StallLevelLen 2
`endif
`ifndef JumpInfoLen
`define JumpInfoLen 4
`endif
`ifndef RAMAddrLen
`define RAMAddrLen 32
`endif
`ifndef Stall_Null
`define Stall_Null 2'd0
`define Stall_Decode 2'd1
`define Stall_Issue 2'd2
`define Stall_All 2'd3
`endif
`ifndef Jump_ID
`define Jump_ID 0
`define Jump_EX 1
`endif

module pipeline_ctrl (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      if_stall_req,
  input  logic                      id_load_use,
  input  logic                      mem_stall_req,
  input  logic                      id_jump_req,
  input  logic [`RAMAddrLen-1:0]    id_jump_target,
  input  logic                      ex_jump_req,
  input  logic [`RAMAddrLen-1:0]    ex_jump_target,
  output logic [`StallLevelLen-1:0] stall_command,
  output logic [`JumpInfoLen-1:0]   jp,
  output logic                      redirect_valid,
  output logic [`RAMAddrLen-1:0]    redirect_pc,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_flush_count
);

  typedef enum logic {
    LU_IDLE,
    LU_BUBBLE
  } lu_state_e;

  lu_state_e lu_q, lu_d;

  logic                   pend_v_q, pend_v_d;
  logic                   pend_ex_q, pend_ex_d;
  logic [`RAMAddrLen-1:0] pend_tgt_q, pend_tgt_d;

  logic                     lu_fire;
  logic                     ex_redir;
  logic                     stall_all;
  logic [`StallLevelLen-1:0] jump_stall;

  assign stall_all  = rdy & mem_stall_req;
  assign jump_stall = if_stall_req ? `Stall_Decode : `Stall_Null;

  always_comb begin
    stall_command  = `Stall_Null;
    jp             = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lu_fire        = 1'b0;
    ex_redir       = 1'b0;
    if (rst) begin
      stall_command = `Stall_Null;
    end else if (!rdy || mem_stall_req) begin
      stall_command = `Stall_All;
    end else if (pend_v_q && (pend_ex_q || !ex_jump_req)) begin
      // a pending ID replay yields to a live EX jump
      if (pend_ex_q) jp[`Jump_EX] = 1'b1;
      else           jp[`Jump_ID] = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = pend_tgt_q;
      stall_command  = jump_stall;
      ex_redir       = pend_ex_q;
    end else if (ex_jump_req) begin
      jp[`Jump_EX]   = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = ex_jump_target;
      stall_command  = jump_stall;
      ex_redir       = 1'b1;
    end else if (id_jump_req) begin
      jp[`Jump_ID]   = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = id_jump_target;
      stall_command  = jump_stall;
    end else if (lu_q == LU_IDLE && id_load_use) begin
      stall_command = `Stall_Issue;
      lu_fire       = 1'b1;
    end else if (if_stall_req) begin
      stall_command = `Stall_Decode;
    end
  end

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_ex_d  = pend_ex_q;
    pend_tgt_d = pend_tgt_q;
    if (stall_all) begin
      if (ex_jump_req) begin
        pend_v_d   = 1'b1;
        pend_ex_d  = 1'b1;
        pend_tgt_d = ex_jump_target;
      end else if (id_jump_req && !(pend_v_q && pend_ex_q)) begin
        pend_v_d   = 1'b1;
        pend_ex_d  = 1'b0;
        pend_tgt_d = id_jump_target;
      end
    end else begin
      pend_v_d = 1'b0;
    end
  end

  always_comb begin
    lu_d = lu_q;
    unique case (lu_q)
      LU_IDLE:   if (lu_fire) lu_d = LU_BUBBLE;
      LU_BUBBLE: if (!stall_all) lu_d = LU_IDLE;
      default:   lu_d = LU_IDLE;
    endcase
    if (ex_redir) lu_d = LU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_q       <= LU_IDLE;
      pend_v_q   <= 1'b0;
      pend_ex_q  <= 1'b0;
      pend_tgt_q <= '0;
    end else if (rdy) begin
      lu_q       <= lu_d;
      pend_v_q   <= pend_v_d;
      pend_ex_q  <= pend_ex_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_all && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect_valid && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Vector-table bench for pipeline_ctrl with an expected-result queue.
// Counter expectations follow PIPE_PERF_CNT_EN.
`ifndef StallLevelLen
`define StallLevelLen 2
`endif
`ifndef JumpInfoLen
`define JumpInfoLen 4
`endif
`ifndef RAMAddrLen
`define RAMAddrLen 32
`endif

module tb_pipeline_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  localparam logic [1:0] SN = 2'd0;
  localparam logic [1:0] SD = 2'd1;
  localparam logic [1:0] SI = 2'd2;
  localparam logic [1:0] SA = 2'd3;
  localparam logic [3:0] J0 = 4'b0000;
  localparam logic [3:0] JI = 4'b0001;
  localparam logic [3:0] JE = 4'b0010;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ifs;
    logic        lu;
    logic        mem;
    logic        idj;
    logic [31:0] idt;
    logic        exj;
    logic [31:0] ext;
    logic [1:0]  es;
    logic [3:0]  ejp;
    logic        erv;
    logic [31:0] epc;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rdy, if_stall_req, id_load_use, mem_stall_req;
  logic id_jump_req, ex_jump_req;
  logic [`RAMAddrLen-1:0] id_jump_target, ex_jump_target;
  logic [`StallLevelLen-1:0] stall_command;
  logic [`JumpInfoLen-1:0] jp;
  logic redirect_valid;
  logic [`RAMAddrLen-1:0] redirect_pc;
  logic [31:0] perf_stall_cycles, perf_flush_count;

  int n_chk = 0;
  int n_fail = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit cnt_ok = 1'b0;
  vec_t vt[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .if_stall_req(if_stall_req),
    .id_load_use(id_load_use),
    .mem_stall_req(mem_stall_req),
    .id_jump_req(id_jump_req),
    .id_jump_target(id_jump_target),
    .ex_jump_req(ex_jump_req),
    .ex_jump_target(ex_jump_target),
    .stall_command(stall_command),
    .jp(jp),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count(perf_flush_count)
  );

  function automatic vec_t mk(
    input logic r, input logic y, input logic ifs,
    input logic lu, input logic mem,
    input logic idj, input logic [31:0] idt,
    input logic exj, input logic [31:0] ext,
    input logic [1:0] es, input logic [3:0] ejp,
    input logic erv, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.rdy = y; v.ifs = ifs; v.lu = lu;
    v.mem = mem; v.idj = idj; v.idt = idt;
    v.exj = exj; v.ext = ext; v.es = es;
    v.ejp = ejp; v.erv = erv; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; rdy = v.rdy; if_stall_req = v.ifs;
    id_load_use = v.lu; mem_stall_req = v.mem;
    id_jump_req = v.idj; id_jump_target = v.idt;
    ex_jump_req = v.exj; ex_jump_target = v.ext;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    chk("stall", idx, 32'(stall_command), 32'(e.es));
    chk("jp", idx, 32'(jp), 32'(e.ejp));
    chk("rv", idx, 32'(redirect_valid), 32'(e.erv));
    chk("pc", idx, 32'(redirect_pc), e.epc);
    if (cnt_ok) begin
      chk("stall_cnt", idx, perf_stall_cycles,
          PERF_EN ? 32'(m_stall) : 32'd0);
      chk("flush_cnt", idx, perf_flush_count,
          PERF_EN ? 32'(m_flush) : 32'd0);
    end
    cnt_ok = 1'b1;
    if (e.rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (e.rdy && e.mem) m_stall++;
      if (e.erv) m_flush++;
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_stall_req = 1'b0;
    id_load_use = 1'b0; mem_stall_req = 1'b0;
    id_jump_req = 1'b0; id_jump_target = '0;
    ex_jump_req = 1'b0; ex_jump_target = '0;

    // r y ifs lu mem idj idt exj ext | es jp rv pc
    vt.push_back(mk(1,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(1,1,0,1,0,1,'h55,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,0,0,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,0,0,1,'h1040, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,0,0,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,0,0,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,JE,1,'h1040));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,1,'h200,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,0,0,1,'h300, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,1,'h400,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,JE,1,'h300));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,1,'h90,1,'h80, SN,JE,1,'h80));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0));
    vt.push_back(mk(0,0,0,1,1,0,0,1,'h999, SA,J0,0,0));
    vt.push_back(mk(0,0,0,0,0,1,'h777,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,1,0,0,1,'h123,0,0, SD,JI,1,'h123));
    vt.push_back(mk(0,1,1,0,0,0,0,0,0, SD,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0));
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,1,'h44, SN,JE,1,'h44));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,1,'h10,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,1,'h20, SN,JE,1,'h20));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,0,0,1,'h30, SA,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,1,'h40,0,0, SN,JE,1,'h30));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,1,'h50,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,1,0,0,0,0,0,0, SD,JI,1,'h50));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,1,1,0,0,0,0, SA,J0,0,0));
    vt.push_back(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,0,1,0,0,1,'h60, SA,J0,0,0));
    vt.push_back(mk(1,1,0,0,0,0,0,0,0, SN,J0,0,0));
    vt.push_back(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // long stall: EX then ID captured, rdy gap keeps slot
    apply(mk(0,1,0,0,1,0,0,1,'hA00, SA,J0,0,0), 100);
    apply(mk(0,1,0,0,1,1,'hB00,0,0, SA,J0,0,0), 101);
    apply(mk(0,0,0,0,0,0,0,0,0, SA,J0,0,0), 102);
    apply(mk(0,1,0,0,1,0,0,0,0, SA,J0,0,0), 103);
    apply(mk(0,1,1,1,0,0,0,0,0, SD,JE,1,'hA00), 104);
    apply(mk(0,1,0,1,0,0,0,0,0, SI,J0,0,0), 105);

    // pending ID survives a rdy gap and replays once
    apply(mk(0,1,0,0,1,1,'hC00,0,0, SA,J0,0,0), 110);
    apply(mk(0,0,0,0,0,0,0,1,'hD00, SA,J0,0,0), 111);
    apply(mk(0,1,0,0,0,0,0,0,0, SN,JI,1,'hC00), 112);
    apply(mk(0,1,0,0,0,0,0,0,0, SN,J0,0,0), 113);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
